// File: rtl/ram_arbiter.sv
// Two-master arbiter for the shared external RAM: the CPU Wishbone port and the MGIA video fetch port.
// Video has priority. The CPU is granted after MAX_VID_RUN back-to-back video wins, and each grant has a timeout.
module ram_arbiter #(
    parameter int unsigned MAX_VID_RUN = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [16:0] c_adr_i,
    input  logic [15:0] c_dat_i,
    input  logic [1:0]  c_sel_i,
    input  logic        c_we_i,
    input  logic        c_stb_i,
    output logic        c_ack_o,
    output logic        c_err_o,
    output logic [15:0] c_dat_o,
    input  logic [16:0] v_adr_i,
    input  logic        v_stb_i,
    output logic        v_ack_o,
    output logic [15:0] v_dat_o,
    output logic [16:0] ram_adr_i,
    output logic [15:0] ram_dat_i,
    output logic [1:0]  ram_sel_i,
    output logic        ram_wen_i,
    output logic        ram_oen_i,
    input  logic        ram_ack_o,
    input  logic [15:0] ram_dat_o
);

    localparam int unsigned     RunW   = $clog2(MAX_VID_RUN + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(MAX_VID_RUN);
    localparam logic [7:0]      TmoMax = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StGntC, StGntV} state_e;

    state_e          r_state, w_state_d, w_arb;
    logic [RunW-1:0] r_run, w_run_d;
    logic [7:0]      r_tmo, w_tmo_d;
    logic            w_gnt_c, w_gnt_v, w_tmo_hit, w_done_c, w_done_v, w_done;

    // A grant whose master dropped its strobe is abandoned: no completion, no ack, no error.
    assign w_gnt_c   = (r_state == StGntC) & c_stb_i;
    assign w_gnt_v   = (r_state == StGntV) & v_stb_i;
    assign w_tmo_hit = (r_tmo == TmoMax) & ~ram_ack_o;
    assign w_done_c  = w_gnt_c & (ram_ack_o | w_tmo_hit);
    assign w_done_v  = w_gnt_v & (ram_ack_o | w_tmo_hit);
    assign w_done    = w_done_c | w_done_v;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= StIdle;
            r_run   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_d;
            r_run   <= w_run_d;
            r_tmo   <= w_tmo_d;
        end
    end

    always_comb begin
        w_run_d = r_run;
        if (!c_stb_i || w_done_c) begin
            w_run_d = '0;
        end else if (w_done_v && (r_run != RunMax)) begin
            w_run_d = r_run + 1'b1;
        end
    end

    // Arbitration uses the run count that includes the video completion happening this cycle.
    always_comb begin
        if (c_stb_i && v_stb_i) begin
            w_arb = (w_run_d == RunMax) ? StGntC : StGntV;
        end else if (c_stb_i) begin
            w_arb = StGntC;
        end else if (v_stb_i) begin
            w_arb = StGntV;
        end else begin
            w_arb = StIdle;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: w_state_d = w_arb;
            StGntC: begin
                if (!c_stb_i)     w_state_d = StIdle;
                else if (w_done_c) w_state_d = w_arb;
            end
            StGntV: begin
                if (!v_stb_i)     w_state_d = StIdle;
                else if (w_done_v) w_state_d = w_arb;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_tmo_d = r_tmo;
        if (w_done || (w_state_d != r_state)) begin
            w_tmo_d = '0;
        end else if ((r_state != StIdle) && !ram_ack_o) begin
            w_tmo_d = r_tmo + 8'd1;
        end
    end

    always_comb begin
        ram_adr_i = '0;
        ram_dat_i = '0;
        ram_sel_i = '0;
        ram_wen_i = 1'b1;
        ram_oen_i = 1'b1;
        c_ack_o   = 1'b0;
        c_err_o   = 1'b0;
        c_dat_o   = '0;
        v_ack_o   = 1'b0;
        v_dat_o   = '0;
        case (r_state)
            StGntC: begin
                ram_adr_i = c_adr_i;
                ram_dat_i = c_dat_i;
                ram_sel_i = c_sel_i;
                ram_wen_i = ~c_we_i;
                ram_oen_i = c_we_i;
                c_ack_o   = c_stb_i & ram_ack_o;
                c_err_o   = c_stb_i & w_tmo_hit;
                c_dat_o   = ram_dat_o;
            end
            StGntV: begin
                ram_adr_i = v_adr_i;
                ram_sel_i = 2'b11;
                ram_oen_i = 1'b0;
                // Video never stalls: a timeout still acks, returning zero data.
                v_ack_o   = v_stb_i & (ram_ack_o | w_tmo_hit);
                v_dat_o   = w_tmo_hit ? 16'h0000 : ram_dat_o;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter for the shared 256KB external RAM.
- Sits directly downstream of the computer's address decoder: CPU-side Wishbone accesses with the RAM enable asserted enter here.
- The MGIA video fetch port is the second master.
- The block drives the external SRAM-style RAM pins and returns acknowledge and read data to the winning master. Video has priority, with a bounded-starvation guarantee for the CPU and a per-transaction timeout.

Parameters:
- MAX_VID_RUN, 4: max consecutive video grants while a CPU request is pending.
- TIMEOUT, 255: cycles a granted transaction may wait for ram_ack_o before forced termination (8-bit counter).

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous reset, active low
- c_adr_i  in  17  CPU word address [17:1]
- c_dat_i  in  16  CPU write data
- c_sel_i  in  2  CPU byte lanes
- c_we_i  in  1  CPU write enable
- c_stb_i  in  1  CPU request (already qualified with RAM enable)
- c_ack_o  out  1  CPU acknowledge
- c_err_o  out  1  CPU timeout error
- c_dat_o  out  16  CPU read data
- v_adr_i  in  17  video word address [17:1]
- v_stb_i  in  1  video read request
- v_ack_o  out  1  video acknowledge
- v_dat_o  out  16  video read data
- ram_adr_i  out  17  RAM address
- ram_dat_i  out  16  RAM write data
- ram_sel_i  out  2  RAM byte lanes (video forces 2'b11)
- ram_wen_i  out  1  RAM write strobe, active low
- ram_oen_i  out  1  RAM output enable, active low
- ram_ack_o  in  1  RAM cycle complete
- ram_dat_o  in  16  RAM read data

Behaviour:
- Reset (reset_ni low, asynchronous):
  - State goes to IDLE; run counter and timeout counter clear to 0.
  - All acks and errors drive 0; ram_wen_i and ram_oen_i drive 1; ram_adr_i, ram_dat_i and ram_sel_i drive 0.
- States: IDLE, GNT_C, GNT_V.
- In GNT_C:
  - RAM outputs mirror c_adr_i, c_dat_i and c_sel_i combinationally.
  - ram_wen_i = ~c_we_i; ram_oen_i = c_we_i.
- In GNT_V:
  - ram_adr_i = v_adr_i, ram_sel_i = 2'b11, ram_wen_i = 1, ram_oen_i = 0.
  - ram_dat_i = 0.
- In IDLE: strobes are deasserted and the address/data outputs are 0.
- c_ack_o = GNT_C & ram_ack_o.
- v_ack_o = GNT_V & ram_ack_o.
- c_dat_o and v_dat_o equal ram_dat_o while their grant is active, and 0 otherwise.
- Arbitration is evaluated in IDLE, and on the cycle a granted transaction completes (ack or timeout). This gives back-to-back hand-off with no idle bubble. Rules in order:
  1. Neither request: go to IDLE.
  2. Only one request: grant it.
  3. Both requesting: grant GNT_C if run counter = MAX_VID_RUN, else GNT_V.
- Run counter:
  - Increments on each video completion while c_stb_i = 1.
  - Clears on any CPU completion, and on any cycle with c_stb_i = 0.
  - Saturates at MAX_VID_RUN.
- Timeout counter:
  - Clears on every grant change; increments each cycle in GNT_C or GNT_V without ram_ack_o.
  - On reaching TIMEOUT, the transaction terminates and arbitration is re-evaluated.
  - CPU timeout: c_err_o pulses 1 cycle, with c_ack_o = 0.
  - Video timeout: v_ack_o pulses with v_dat_o = 16'h0000 (MGIA must never stall).
- Requesters hold stb and address stable until ack/err. If a master drops stb mid-grant before ack, the arbiter returns to arbitration the next cycle; no ack or err is issued.
- ram_ack_o and timeout in the same cycle: ack wins, no error.
- ram_ack_o while IDLE is ignored.
- Reset mid-transaction: strobes deassert immediately and no ack is issued.

Test Plan:
- CPU-only read, c_adr_i=17'h00010, RAM acks after 2 cycles with 16'hBEEF -> ram_oen_i=0, ram_wen_i=1 for 2 cycles; c_ack_o single pulse with c_dat_o=16'hBEEF; v_ack_o stays 0.
- CPU write c_dat_i=16'h1234, c_sel_i=2'b01 -> ram_wen_i=0, ram_sel_i=2'b01, ram_dat_i=16'h1234 until ack; c_ack_o pulses once.
- Both stb held continuously, RAM acks every cycle, MAX_VID_RUN=4 -> grant sequence V,V,V,V,C,V,V,V,V,C; no idle cycle between grants.
- CPU request with RAM never acking, TIMEOUT=255 -> c_err_o pulses exactly 255 cycles after grant; c_ack_o never asserts; state returns to IDLE.
- Video request timeout -> v_ack_o pulses with v_dat_o=0 at cycle 255.
- reset_ni asserted low asynchronously during GNT_V -> ram_oen_i=1 and v_ack_o=0 without waiting for a clk_i edge; after release with no requests, state stays IDLE.
